// File: rtl/block_plotter_if.sv
// Bundle of draw-request and VGA-adapter signals for block_plotter.
// master: the side issuing draw requests and observing the pixel stream.
// slave : the plotter itself.
interface block_plotter_if;
  logic        start;
  logic        erase;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [15:0] shape;
  logic [2:0]  colour;
  logic        busy;
  logic        done;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot;

  modport master (
    output start, erase, x0, y0, shape, colour,
    input  busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );

  modport slave (
    input  start, erase, x0, y0, shape, colour,
    output busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
  );
endinterface

// File: rtl/block_plotter.sv
// block_plotter: scans a 4x4-cell piece, one pixel per clock, and emits
// VGA adapter write strobes for every pixel of every set cell.
// Scan order (innermost last): cell row, cell column, pixel row, pixel column.
// Optional feature macro: BLOCK_PLOTTER_CLIP_EN -- suppresses plot for pixels
// whose untruncated coordinate lies beyond X_MAX / Y_MAX.
module block_plotter #(
  parameter int CELL  = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  block_plotter_if.slave bus
);
  localparam int LC = $clog2(CELL);
  localparam int CW = 4 + 2 * LC;
  localparam int P  = 16 * CELL * CELL;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

`ifdef BLOCK_PLOTTER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    x0_q;
  logic [6:0]    y0_q;
  logic [15:0]   shape_q;
  logic [2:0]    colour_q;
  logic          erase_q;
  logic          busy_q;
  logic          done_q;
  logic          plot_q;
  logic [7:0]    vga_x_q;
  logic [6:0]    vga_y_q;
  logic [2:0]    vga_color_q;

  logic [CW-1:0] cnt_d;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [15:0]   base_shape;
  logic [LC-1:0] px;
  logic [LC-1:0] py;
  logic [1:0]    cell_col;
  logic [1:0]    cell_row;
  logic [8:0]    x_full;
  logic [7:0]    y_full;
  logic          clip;
  logic          plot_d;

  // Next pixel to present: pixel 0 straight from the request inputs when a
  // scan starts, otherwise the following pixel from the latched request.
  always_comb begin
    if (state_q == IDLE) begin
      base_x     = bus.x0;
      base_y     = bus.y0;
      base_shape = bus.shape;
      cnt_d      = '0;
    end else begin
      base_x     = x0_q;
      base_y     = y0_q;
      base_shape = shape_q;
      cnt_d      = cnt_q + CW'(1);
    end
  end

  // CELL is a power of two, so col*CELL+px is just {col, px}.
  assign px       = cnt_d[LC-1:0];
  assign py       = cnt_d[2*LC-1:LC];
  assign cell_col = cnt_d[2*LC+1:2*LC];
  assign cell_row = cnt_d[2*LC+3:2*LC+2];
  assign x_full   = {1'b0, base_x} + 9'({cell_col, px});
  assign y_full   = {1'b0, base_y} + 8'({cell_row, py});
  assign clip     = CLIP_EN && ((int'(x_full) > X_MAX) || (int'(y_full) > Y_MAX));
  assign plot_d   = base_shape[{cell_row, cell_col}] && !clip;

  // Control FSM with registered outputs; coordinates hold outside DRAW.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      shape_q     <= '0;
      colour_q    <= '0;
      erase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      plot_q      <= 1'b0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          plot_q <= 1'b0;
          if (bus.start) begin
            x0_q        <= bus.x0;
            y0_q        <= bus.y0;
            shape_q     <= bus.shape;
            colour_q    <= bus.colour;
            erase_q     <= bus.erase;
            state_q     <= DRAW;
            busy_q      <= 1'b1;
            cnt_q       <= cnt_d;
            vga_x_q     <= x_full[7:0];
            vga_y_q     <= y_full[6:0];
            vga_color_q <= bus.erase ? 3'b000 : bus.colour;
            plot_q      <= plot_d;
          end
        end
        DRAW: begin
          if (cnt_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            plot_q  <= 1'b0;
          end else begin
            cnt_q       <= cnt_d;
            vga_x_q     <= x_full[7:0];
            vga_y_q     <= y_full[6:0];
            vga_color_q <= erase_q ? 3'b000 : colour_q;
            plot_q      <= plot_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.plot      = plot_q;
  assign bus.VGA_X     = vga_x_q;
  assign bus.VGA_Y     = vga_y_q;
  assign bus.VGA_COLOR = vga_color_q;
endmodule

// File: tb/tb_block_plotter.sv
// Self-checking bench for block_plotter: table of directed pieces, random
// pieces against a per-pixel model, and hand-written reset/back-to-back runs.
module tb_block_plotter;
  localparam int CELL  = 4;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
  localparam int P     = 16 * CELL * CELL;
`ifdef BLOCK_PLOTTER_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic CLOCK_50 = 1'b0;
  logic Reset    = 1'b1;
  block_plotter_if bus ();

  block_plotter #(.CELL(CELL), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected pixel stream of the current scan
  logic [7:0] m_x [P];
  logic [6:0] m_y [P];
  logic       m_p [P];
  logic [2:0] m_c;
  int         m_plots;

  typedef struct {
    string       name;
    logic [7:0]  x0;
    logic [6:0]  y0;
    logic [15:0] shape;
    logic [2:0]  colour;
    logic        erase;
    int          exp_plots;
    logic [7:0]  exp_last_x;
    logic [6:0]  exp_last_y;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the piece geometrically, one pixel per scan slot.
  task automatic build_model(input logic [7:0] x, input logic [6:0] y,
                             input logic [15:0] sh, input logic [2:0] col,
                             input logic er);
    int k = 0;
    m_plots = 0;
    m_c = er ? 3'b000 : col;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int yy = 0; yy < CELL; yy++)
          for (int xx = 0; xx < CELL; xx++) begin
            int fx = int'(x) + c * CELL + xx;
            int fy = int'(y) + r * CELL + yy;
            m_x[k] = fx[7:0];
            m_y[k] = fy[6:0];
            m_p[k] = sh[r*4+c] && (!CLIP || (fx <= X_MAX && fy <= Y_MAX));
            if (m_p[k]) m_plots++;
            k++;
          end
  endtask

  // Called at a negedge in an IDLE cycle; returns at a negedge in IDLE.
  task automatic do_scan(input string name, input logic [7:0] x, input logic [6:0] y,
                         input logic [15:0] sh, input logic [2:0] col, input logic er,
                         input bit hold_start, output int plots,
                         output logic [7:0] last_x, output logic [6:0] last_y);
    int mism = 0;
    plots  = 0;
    last_x = '0;
    last_y = '0;
    build_model(x, y, sh, col, er);
    bus.x0 = x; bus.y0 = y; bus.shape = sh; bus.colour = col; bus.erase = er;
    bus.start = 1'b1;
    for (int k = 0; k < P; k++) begin
      @(negedge CLOCK_50);
      if (k == 0) begin
        if (!hold_start) bus.start = 1'b0;
        // the scan must use latched values, so disturb the live inputs
        bus.x0 = 8'($urandom); bus.y0 = 7'($urandom);
        bus.shape = 16'($urandom); bus.colour = 3'($urandom); bus.erase = 1'($urandom);
      end
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.plot !== m_p[k] ||
          bus.VGA_X !== m_x[k] || bus.VGA_Y !== m_y[k] || bus.VGA_COLOR !== m_c)
        mism++;
      if (bus.plot === 1'b1) begin
        plots++;
        last_x = bus.VGA_X;
        last_y = bus.VGA_Y;
      end
    end
    check({name, "_pixel_errors"}, mism, 0);
    check({name, "_model_plots"}, plots, m_plots);
    @(negedge CLOCK_50);
    check({name, "_done_cycle"}, {bus.done, bus.busy, bus.plot}, 3'b100);
    check({name, "_hold_x"}, bus.VGA_X, m_x[P-1]);
    @(negedge CLOCK_50);
    check({name, "_idle_after"}, {bus.done, bus.busy, bus.plot}, 3'b000);
    $display("scan %s: x0=%0d y0=%0d shape=%h plots=%0d", name, x, y, sh, plots);
  endtask

  vec_t vecs [6];

  initial begin
    int plots;
    logic [7:0] lx;
    logic [6:0] ly;
    int dones;

    vecs[0] = '{"o_piece", 8'd79, 7'd39, 16'h0033, 3'b110, 1'b0, 64, 8'd86, 7'd46};
    vecs[1] = '{"i_erase", 8'd10, 7'd20, 16'h000F, 3'b111, 1'b1, 64, 8'd25, 7'd23};
    vecs[2] = '{"empty",   8'd30, 7'd30, 16'h0000, 3'b011, 1'b0, 0,  8'd0,  7'd0};
`ifdef BLOCK_PLOTTER_CLIP_EN
    vecs[3] = '{"edge_x",  8'd156, 7'd0, 16'h000F, 3'b010, 1'b0, 16, 8'd159, 7'd3};
    vecs[4] = '{"wrap",    8'd250, 7'd126, 16'h0001, 3'b101, 1'b0, 0, 8'd0, 7'd0};
`else
    vecs[3] = '{"edge_x",  8'd156, 7'd0, 16'h000F, 3'b010, 1'b0, 64, 8'd171, 7'd3};
    vecs[4] = '{"wrap",    8'd250, 7'd126, 16'h0001, 3'b101, 1'b0, 16, 8'd253, 7'd1};
`endif
    vecs[5] = '{"full",    8'd0, 7'd0, 16'hFFFF, 3'b001, 1'b0, 256, 8'd15, 7'd15};

    bus.start = 1'b0; bus.erase = 1'b0; bus.x0 = '0; bus.y0 = '0;
    bus.shape = '0; bus.colour = '0;
    repeat (3) @(negedge CLOCK_50);
    check("reset_state", {bus.busy, bus.done, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}, 0);
    Reset = 1'b0;
    @(negedge CLOCK_50);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_scan(vecs[i].name, vecs[i].x0, vecs[i].y0, vecs[i].shape, vecs[i].colour,
              vecs[i].erase, 1'b0, plots, lx, ly);
      check({vecs[i].name, "_plots"}, plots, vecs[i].exp_plots);
      if (vecs[i].exp_plots > 0) begin
        check({vecs[i].name, "_last_x"}, lx, vecs[i].exp_last_x);
        check({vecs[i].name, "_last_y"}, ly, vecs[i].exp_last_y);
      end
    end

    // Random pieces against the model
    for (int i = 0; i < 6; i++)
      do_scan("random", 8'($urandom), 7'($urandom), 16'($urandom), 3'($urandom),
              1'($urandom), 1'b0, plots, lx, ly);

    // start held high: back-to-back scans, mid-scan start ignored
    do_scan("b2b_first", 8'd40, 7'd50, 16'h0272, 3'b100, 1'b0, 1'b1, plots, lx, ly);
    do_scan("b2b_second", 8'd60, 7'd10, 16'h4444, 3'b001, 1'b0, 1'b0, plots, lx, ly);

    // Reset at pixel 100, no done afterwards
    build_model(8'd20, 7'd20, 16'hFFFF, 3'b111, 1'b0);
    bus.x0 = 8'd20; bus.y0 = 7'd20; bus.shape = 16'hFFFF; bus.colour = 3'b111;
    bus.erase = 1'b0; bus.start = 1'b1;
    for (int k = 0; k <= 100; k++) begin
      @(negedge CLOCK_50);
      bus.start = 1'b0;
    end
    check("px100_x", bus.VGA_X, m_x[100]);
    check("px100_busy", bus.busy, 1'b1);
    Reset = 1'b1;
    @(negedge CLOCK_50);
    check("midscan_reset", {bus.busy, bus.done, bus.plot, bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR}, 0);
    Reset = 1'b0;
    dones = 0;
    repeat (P + 10) begin
      @(negedge CLOCK_50);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    check("no_done_after_reset", dones, 0);
    $display("scan reset_at_100: outputs cleared, activity=%0d", dones);

    // Reset wins over start on the same edge
    bus.start = 1'b1; Reset = 1'b1;
    @(negedge CLOCK_50);
    bus.start = 1'b0; Reset = 1'b0;
    @(negedge CLOCK_50);
    check("reset_over_start", {bus.busy, bus.plot}, 2'b00);

    // Scan still works after reset
    do_scan("after_reset", 8'd5, 7'd5, 16'h8001, 3'b010, 1'b0, 1'b0, plots, lx, ly);
    check("after_reset_plots", plots, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/block_plotter.md
BLOCK_PLOTTER -- requirements
Module: block_plotter

Interface
REQ-001 SHALL have parameter CELL, default 4: cell edge in pixels; legal values 2, 4, 8.
REQ-002 SHALL have parameter X_MAX, default 159: last visible column.
REQ-003 SHALL have parameter Y_MAX, default 119: last visible row.
REQ-004 SHALL have port CLOCK_50 input 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset input 1: synchronous, active-high reset.
REQ-006 SHALL have port start input 1: draw request, sampled in IDLE only.
REQ-007 SHALL have port erase input 1: draw in colour 3'b000 instead of the colour input.
REQ-008 SHALL have port x0 input 8: pixel column of the piece's top-left corner.
REQ-009 SHALL have port y0 input 7: pixel row of the piece's top-left corner.
REQ-010 SHALL have port shape input 16: 4x4 cell mask; bit (row*4+col); bit 0 is top-left.
REQ-011 SHALL have port colour input 3: RGB piece colour.
REQ-012 SHALL have port busy output 1: scan in progress.
REQ-013 SHALL have port done output 1: one-cycle pulse when the scan completes.
REQ-014 SHALL have port VGA_X output 8: pixel column to the VGA adapter.
REQ-015 SHALL have port VGA_Y output 7: pixel row to the VGA adapter.
REQ-016 SHALL have port VGA_COLOR output 3: pixel colour to the VGA adapter.
REQ-017 SHALL have port plot output 1: write strobe to the VGA adapter.

Function
REQ-018 SHALL implement the states IDLE, DRAW and DONE.
REQ-019 SHALL, in IDLE with start=1 at edge N, latch x0, y0, shape, colour and erase, then enter DRAW.
REQ-020 SHALL hold busy=1 from cycle N+1 until the last DRAW cycle inclusive.
REQ-021 SHALL scan P=16*CELL*CELL pixels: cell rows 0..3, then cell columns 0..3, then pixel rows within the cell, then pixel columns within the cell (innermost).
REQ-022 SHALL present pixel k (k=0..P-1) on registered outputs during cycle N+1+k.
REQ-023 SHALL compute VGA_X = x0+col*CELL+px and VGA_Y = y0+row*CELL+py, truncated to 8 and 7 bits.
REQ-024 SHALL assert plot for a pixel only when its cell's shape bit is 1.
REQ-025 SHALL drive VGA_COLOR as the latched colour, or 3'b000 when erase was latched.
REQ-026 SHALL enter DONE after pixel P-1, pulse done=1 with busy=0 for exactly one cycle (N+1+P), then return to IDLE.
REQ-027 SHALL hold plot=0 in IDLE and DONE.
REQ-028 SHALL ignore start while busy or in DONE; start=1 in the IDLE cycle right after DONE begins a new scan.
REQ-029 SHALL, for shape=16'h0000, still run the full P-cycle scan with plot=0 throughout, followed by done.
REQ-030 SHALL leave VGA_X, VGA_Y and VGA_COLOR holding their last values outside DRAW.

Reset
REQ-031 SHALL, on Reset=1 at any edge including mid-scan, enter IDLE and clear busy, done, plot, VGA_X, VGA_Y, VGA_COLOR and all latched inputs to 0 on that edge.
REQ-032 SHALL give Reset priority over start on the same edge.

Configuration
REQ-033 SHALL, with BLOCK_PLOTTER_CLIP_EN defined, force plot=0 for any pixel whose untruncated column exceeds X_MAX or whose untruncated row exceeds Y_MAX, with scan timing unchanged.
REQ-034 SHALL, without BLOCK_PLOTTER_CLIP_EN, apply no clipping: coordinates wrap per REQ-023 and plot follows REQ-024 only.

Verification
REQ-035 SHALL cover: O piece shape=16'h0033, x0=8'd79, y0=7'd39, colour=3'b110, CELL=4 -> 64 plot pulses at columns 79..86 and rows 39..46, colour 110; done at N+257.
REQ-036 SHALL cover: I piece shape=16'h000F, erase=1 -> 64 plot pulses on row cells 0 only, VGA_COLOR=000.
REQ-037 SHALL cover: start held high continuously -> scans back-to-back, each separated by exactly one DONE cycle; start ignored mid-scan.
REQ-038 SHALL cover: Reset=1 at pixel 100 -> next cycle busy=0, plot=0, all outputs 0; no done pulse.
REQ-039 SHALL cover: x0=8'd156, shape=16'h000F, CLIP_EN defined -> plot only for columns 156..159 (4 columns x 4 rows = 16 pulses); undefined -> 64 pulses with columns 156..171.
REQ-040 SHALL cover: shape=16'h0000 -> zero plot pulses; done at N+257.
